flex_updown_counter: RTL and testbench

Parametrised successor to the team's flex counter. Counts up or down over the range 1..rollover_val, with wrap or saturate mode, parallel load and a built-in enable prescaler. It also provides registered terminal flags and a one-cycle wrap pulse. Used for baud/bit timing and packet-length counting, where the plain up-counter is insufficient.

---
 rtl/flex_cnt_pkg.sv | 14 +
 rtl/flex_updown_counter_if.sv | 32 +++
 rtl/flex_prescaler.sv | 26 ++
 rtl/flex_updown_counter.sv | 100 ++++++++++
 tb/tb_flex_updown_counter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/flex_cnt_pkg.sv
// rtl/flex_cnt_pkg.sv - shared types for the flex up/down counter
package flex_cnt_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_t;

endpackage

// File: rtl/flex_updown_counter_if.sv
// rtl/flex_updown_counter_if.sv - control and status bundle for the flex up/down counter
interface flex_updown_counter_if #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int PRESCALE_BITS = 4
);
    logic                     clear;
    logic                     load;
    logic [NUM_CNT_BITS-1:0]  load_val;
    logic [NUM_CNT_BITS-1:0]  clear_val;
    logic                     count_enable;
    logic                     count_up;
    logic                     saturate;
    logic [NUM_CNT_BITS-1:0]  rollover_val;
    logic [PRESCALE_BITS-1:0] prescale_div;
    logic [NUM_CNT_BITS-1:0]  count_out;
    logic                     rollover_flag;
    logic                     bottom_flag;
    logic                     wrap_pulse;
    logic                     sat_flag;

    modport master (
        output clear, load, load_val, clear_val, count_enable, count_up,
               saturate, rollover_val, prescale_div,
        input  count_out, rollover_flag, bottom_flag, wrap_pulse, sat_flag
    );

    modport slave (
        input  clear, load, load_val, clear_val, count_enable, count_up,
               saturate, rollover_val, prescale_div,
        output count_out, rollover_flag, bottom_flag, wrap_pulse, sat_flag
    );
endinterface

// File: rtl/flex_prescaler.sv
// rtl/flex_prescaler.sv - enable divider producing one tick per (div+1) enabled cycles
module flex_prescaler #(
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     restart,
    input  logic                     enable,
    input  logic [PRESCALE_BITS-1:0] div,
    output logic                     tick
);
    logic [PRESCALE_BITS-1:0] r_cnt;

    assign tick = enable && (r_cnt == div);

    // Phase counter: restart forces 0, enabled cycles advance, disabled cycles hold the phase
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/flex_updown_counter.sv
// rtl/flex_updown_counter.sv - up/down counter with wrap/saturate, load, prescaler and registered flags
module flex_updown_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS  = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    flex_updown_counter_if.slave  bus
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_roll;
    logic                    r_bot;
    logic                    r_wrap;
    logic                    r_sat;

    logic [NUM_CNT_BITS-1:0] w_next;
    logic                    w_wrap;
    logic                    w_tick;
    logic                    w_restart;
    logic                    w_sat_next;
    count_dir_t              w_dir;
    count_mode_t             w_mode;

    assign w_restart = bus.clear || bus.load;
    assign w_dir     = bus.count_up ? DIR_UP : DIR_DOWN;
    assign w_mode    = bus.saturate ? MODE_SAT : MODE_WRAP;

    flex_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk     (clk),
        .n_rst   (n_rst),
        .restart (w_restart),
        .enable  (bus.count_enable),
        .div     (bus.prescale_div),
        .tick    (w_tick)
    );

    // Next count: clear > load > step on tick > hold; out-of-range values behave as terminal
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        if (bus.clear) begin
            w_next = bus.clear_val;
        end else if (bus.load) begin
            w_next = bus.load_val;
        end else if (w_tick && (bus.rollover_val != '0)) begin
            if (w_dir == DIR_UP) begin
                if (r_count >= bus.rollover_val) begin
                    w_next = (w_mode == MODE_SAT) ? bus.rollover_val : ONE;
                    w_wrap = (w_mode == MODE_WRAP);
                end else begin
                    w_next = r_count + ONE;
                end
            end else begin
                if (r_count <= ONE) begin
                    w_next = (w_mode == MODE_SAT) ? ONE : bus.rollover_val;
                    w_wrap = (w_mode == MODE_WRAP);
                end else begin
                    w_next = r_count - ONE;
                end
            end
        end
    end

    // Saturation flag looks at the terminal of the direction currently selected
    always_comb begin
        w_sat_next = 1'b0;
        if (w_mode == MODE_SAT) begin
            w_sat_next = (w_dir == DIR_UP) ? (w_next == bus.rollover_val) : (w_next == ONE);
        end
    end

    // Count and flags registered together so the flags line up with count_out
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_roll  <= 1'b0;
            r_bot   <= 1'b0;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_roll  <= (w_next == bus.rollover_val);
            r_bot   <= (w_next == ONE);
            r_wrap  <= w_wrap;
            r_sat   <= w_sat_next;
        end
    end

    assign bus.count_out     = r_count;
    assign bus.rollover_flag = r_roll;
    assign bus.bottom_flag   = r_bot;
    assign bus.wrap_pulse    = r_wrap;
    assign bus.sat_flag      = r_sat;
endmodule

// File: tb/tb_flex_updown_counter.sv
// tb/tb_flex_updown_counter.sv - self-checking bench for flex_updown_counter
module tb_flex_updown_counter;
    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_errors;

    flex_updown_counter_if #(.NUM_CNT_BITS(4), .PRESCALE_BITS(4)) bus ();

    flex_updown_counter #(.NUM_CNT_BITS(4), .PRESCALE_BITS(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules
    int m_cnt, m_phase;
    int m_roll, m_bot, m_wrap, m_sat;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_cnt = 0; m_phase = 0;
            m_roll = 0; m_bot = 0; m_wrap = 0; m_sat = 0;
        end else begin
            int  rv, nc, div;
            bit  tick;
            rv   = int'(bus.rollover_val);
            div  = int'(bus.prescale_div);
            tick = bus.count_enable && (m_phase == div);
            nc   = m_cnt;
            m_wrap = 0;
            if (bus.clear) begin
                nc = int'(bus.clear_val); m_phase = 0;
            end else if (bus.load) begin
                nc = int'(bus.load_val); m_phase = 0;
            end else begin
                if (bus.count_enable) m_phase = tick ? 0 : (m_phase + 1) % 16;
                if (tick && rv != 0) begin
                    if (bus.count_up) begin
                        if (m_cnt >= rv) begin
                            if (bus.saturate) nc = rv; else begin nc = 1; m_wrap = 1; end
                        end else nc = m_cnt + 1;
                    end else begin
                        if (m_cnt <= 1) begin
                            if (bus.saturate) nc = 1; else begin nc = rv; m_wrap = 1; end
                        end else nc = m_cnt - 1;
                    end
                end
            end
            m_cnt  = nc;
            m_roll = (nc == rv);
            m_bot  = (nc == 1);
            m_sat  = bus.saturate && (bus.count_up ? (nc == rv) : (nc == 1));
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model count_out", int'(bus.count_out), m_cnt);
        check("model rollover_flag", int'(bus.rollover_flag), m_roll);
        check("model bottom_flag", int'(bus.bottom_flag), m_bot);
        check("model wrap_pulse", int'(bus.wrap_pulse), m_wrap);
        check("model sat_flag", int'(bus.sat_flag), m_sat);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic step_cnt(input string name, input int exp_cnt);
        cyc();
        check(name, int'(bus.count_out), exp_cnt);
    endtask

    initial begin
        int exp1[8];
        n_checks = 0;
        n_errors = 0;
        n_rst = 1'b0;
        bus.clear = 0; bus.load = 0; bus.load_val = 0; bus.clear_val = 0;
        bus.count_enable = 0; bus.count_up = 1; bus.saturate = 0;
        bus.rollover_val = 4'd5; bus.prescale_div = 0;
        repeat (2) @(negedge clk);
        check("reset count_out", int'(bus.count_out), 0);
        check("reset flags", int'({bus.rollover_flag, bus.bottom_flag, bus.wrap_pulse, bus.sat_flag}), 0);
        n_rst = 1'b1;

        // Up, wrap, rollover 5
        bus.count_enable = 1;
        exp1 = '{1, 2, 3, 4, 5, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            step_cnt("up wrap count", exp1[i]);
            check("up wrap rollover_flag", int'(bus.rollover_flag), (i == 4) ? 1 : 0);
            check("up wrap wrap_pulse", int'(bus.wrap_pulse), (i == 5) ? 1 : 0);
        end

        // Down, wrap, load 2
        bus.count_up = 0; bus.load = 1; bus.load_val = 4'd2;
        step_cnt("down load", 2);
        bus.load = 0;
        step_cnt("down count", 1);
        check("down bottom_flag", int'(bus.bottom_flag), 1);
        step_cnt("down wrap count", 5);
        check("down wrap_pulse", int'(bus.wrap_pulse), 1);
        step_cnt("down after wrap", 4);
        check("down wrap_pulse low", int'(bus.wrap_pulse), 0);

        // Up, saturate, rollover 3
        bus.count_up = 1; bus.saturate = 1; bus.rollover_val = 4'd3;
        bus.clear = 1; bus.clear_val = 4'd1;
        step_cnt("sat clear", 1);
        bus.clear = 0;
        step_cnt("sat up", 2);
        check("sat flag low", int'(bus.sat_flag), 0);
        for (int i = 0; i < 3; i++) begin
            step_cnt("sat hold top", 3);
            check("sat flag top", int'(bus.sat_flag), 1);
        end
        bus.count_up = 0;
        step_cnt("sat down", 2);
        check("sat flag mid", int'(bus.sat_flag), 0);
        for (int i = 0; i < 2; i++) begin
            step_cnt("sat hold bottom", 1);
            check("sat flag bottom", int'(bus.sat_flag), 1);
        end

        // Prescaler div 2, phase kept across disable
        bus.saturate = 0; bus.count_up = 1; bus.rollover_val = 4'd5;
        bus.prescale_div = 4'd2; bus.clear = 1; bus.clear_val = 0;
        step_cnt("presc clear", 0);
        bus.clear = 0;
        begin
            int exp4[7];
            exp4 = '{0, 0, 1, 1, 1, 2, 2};
            for (int i = 0; i < 7; i++) step_cnt("presc count", exp4[i]);
        end
        bus.count_enable = 0;
        for (int i = 0; i < 4; i++) step_cnt("presc disabled", 2);
        bus.count_enable = 1;
        step_cnt("presc resume", 2);
        step_cnt("presc resume tick", 3);

        // Clear beats load; load during tick restarts prescaler
        bus.clear = 1; bus.load = 1; bus.clear_val = 4'd4; bus.load_val = 4'd2;
        step_cnt("clear over load", 4);
        bus.clear = 0; bus.load = 0;
        step_cnt("pre-load 1", 4);
        step_cnt("pre-load 2", 4);
        bus.load = 1; bus.load_val = 4'd3;
        step_cnt("load on tick", 3);
        bus.load = 0;
        step_cnt("post-load 1", 3);
        step_cnt("post-load 2", 3);
        step_cnt("post-load tick", 4);

        // Out-of-range load returns into range with a wrap
        bus.prescale_div = 0; bus.load = 1; bus.load_val = 4'd9;
        step_cnt("load 9", 9);
        check("load no wrap_pulse", int'(bus.wrap_pulse), 0);
        bus.load = 0;
        step_cnt("oor step", 1);
        check("oor wrap_pulse", int'(bus.wrap_pulse), 1);
        step_cnt("oor next", 2);

        // Asynchronous reset between edges
        #2;
        n_rst = 1'b0;
        #1;
        check("async reset count", int'(bus.count_out), 0);
        check("async reset flags", int'({bus.rollover_flag, bus.bottom_flag, bus.wrap_pulse, bus.sat_flag}), 0);
        @(negedge clk);
        n_rst = 1'b1;
        step_cnt("resume after reset", 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            bus.clear        = ($urandom_range(0, 15) == 0);
            bus.load         = ($urandom_range(0, 15) == 0);
            bus.clear_val    = 4'($urandom_range(0, 15));
            bus.load_val     = 4'($urandom_range(0, 15));
            bus.count_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.count_up = ~bus.count_up;
            if ($urandom_range(0, 15) == 0) bus.saturate = ~bus.saturate;
            if ($urandom_range(0, 31) == 0) bus.rollover_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) bus.prescale_div = 4'($urandom_range(0, 3));
            if (i == 1500) begin
                #1 n_rst = 1'b0;
                #2 n_rst = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
